bcd_display_scanner: RTL and testbench

- Consumes the four BCD digits (BCD3..BCD0) produced by the trigger-driven BCD counter block.
- Drives a 4-digit common-anode 7-segment display by time-multiplexing the digits.
- Latches all four digits once per frame so no mixed old/new value is ever shown.
- Renders the overflow code 4'hF as a dash.

---
 rtl/seg7_pkg.sv | 22 ++
 rtl/bcd_to_seg7.sv | 27 ++
 rtl/bcd_display_scanner.sv | 100 ++++++++++
 tb/tb_bcd_display_scanner.sv | 153 +++++++++++++++
 4 files changed

// File: rtl/seg7_pkg.sv
// rtl/seg7_pkg.sv - segment codes and types shared by the BCD display scanner
package seg7_pkg;

    typedef logic [6:0] seg_t;

    // gfedcba, active-low
    localparam seg_t SEG_0     = 7'b1000000;
    localparam seg_t SEG_1     = 7'b1111001;
    localparam seg_t SEG_2     = 7'b0100100;
    localparam seg_t SEG_3     = 7'b0110000;
    localparam seg_t SEG_4     = 7'b0011001;
    localparam seg_t SEG_5     = 7'b0010010;
    localparam seg_t SEG_6     = 7'b0000010;
    localparam seg_t SEG_7     = 7'b1111000;
    localparam seg_t SEG_8     = 7'b0000000;
    localparam seg_t SEG_9     = 7'b0010000;
    localparam seg_t SEG_DASH  = 7'b0111111;
    localparam seg_t SEG_BLANK = 7'b1111111;

    localparam logic [3:0] BCD_OVF = 4'hF;

endpackage

// File: rtl/bcd_to_seg7.sv
// rtl/bcd_to_seg7.sv - combinational BCD digit to active-low 7-segment decoder
module bcd_to_seg7
    import seg7_pkg::*;
(
    input  logic [3:0] bcd,
    output logic [6:0] seg
);

    always_comb begin
        seg = SEG_BLANK;
        case (bcd)
            4'd0:    seg = SEG_0;
            4'd1:    seg = SEG_1;
            4'd2:    seg = SEG_2;
            4'd3:    seg = SEG_3;
            4'd4:    seg = SEG_4;
            4'd5:    seg = SEG_5;
            4'd6:    seg = SEG_6;
            4'd7:    seg = SEG_7;
            4'd8:    seg = SEG_8;
            4'd9:    seg = SEG_9;
            BCD_OVF: seg = SEG_DASH;
            default: seg = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/bcd_display_scanner.sv
// rtl/bcd_display_scanner.sv - 4-digit multiplexed 7-segment scanner with per-frame latch
// Optional: LEADING_ZERO_BLANK_EN blanks leading zero digits of the latched frame.
module bcd_display_scanner
    import seg7_pkg::*;
#(
    parameter int SCAN_PERIOD = 100000
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic [3:0] BCD0,
    input  logic [3:0] BCD1,
    input  logic [3:0] BCD2,
    input  logic [3:0] BCD3,
    output logic [6:0] Seg,
    output logic       Dp,
    output logic [3:0] An,
    output logic       FrameStart
);

    localparam int CNT_W = $clog2(SCAN_PERIOD);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SCAN_PERIOD - 1);

    logic [CNT_W-1:0] cnt;
    logic [1:0]       idx;
    logic [1:0]       nxt_idx;
    logic [15:0]      frame;
    logic             tick;
    logic             wrap;
    logic [3:0]       nxt_digit;
    seg_t             dec_seg;
    seg_t             nxt_seg;

    assign tick    = (cnt == CNT_LAST);
    assign wrap    = tick && (idx == 2'd3);
    assign nxt_idx = idx + 2'd1;
    assign Dp      = 1'b1;

    // On the latching edge digit 0 comes straight from the input so it shows with no extra latency.
    always_comb begin
        nxt_digit = frame[{nxt_idx, 2'b00} +: 4];
        if (wrap) begin
            nxt_digit = BCD0;
        end
    end

    bcd_to_seg7 u_dec (
        .bcd (nxt_digit),
        .seg (dec_seg)
    );

`ifdef LEADING_ZERO_BLANK_EN
    logic [3:0] lz;
    logic [3:0] lz_next;

    always_comb begin
        lz_next    = 4'b0000;
        lz_next[3] = (BCD3 == 4'd0);
        lz_next[2] = lz_next[3] && (BCD2 == 4'd0);
        lz_next[1] = lz_next[2] && (BCD1 == 4'd0);
    end

    // lz[0] stays 0 so the ones digit is never blanked.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            lz <= 4'b0000;
        end else if (wrap) begin
            lz <= lz_next;
        end
    end

    assign nxt_seg = lz[nxt_idx] ? SEG_BLANK : dec_seg;
`else
    assign nxt_seg = dec_seg;
`endif

    always_ff @(posedge Clk) begin
        if (Reset) begin
            cnt        <= '0;
            idx        <= 2'd3;
            frame      <= 16'hEEEE;
            An         <= 4'b1111;
            Seg        <= SEG_BLANK;
            FrameStart <= 1'b0;
        end else begin
            FrameStart <= wrap;
            if (tick) begin
                cnt <= '0;
                idx <= nxt_idx;
                An  <= ~(4'b0001 << nxt_idx);
                Seg <= nxt_seg;
                if (wrap) begin
                    frame <= {BCD3, BCD2, BCD1, BCD0};
                end
            end else begin
                cnt <= cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_bcd_display_scanner.sv
// tb/tb_bcd_display_scanner.sv - randomized self-checking bench for bcd_display_scanner
module tb_bcd_display_scanner;

    localparam int SP = 4;

    logic       Clk = 1'b0;
    logic       Reset;
    logic [3:0] BCD0, BCD1, BCD2, BCD3;
    logic [6:0] Seg;
    logic       Dp;
    logic [3:0] An;
    logic       FrameStart;

    always #5 Clk = ~Clk;

    bcd_display_scanner #(.SCAN_PERIOD(SP)) dut (
        .Clk        (Clk),
        .Reset      (Reset),
        .BCD0       (BCD0),
        .BCD1       (BCD1),
        .BCD2       (BCD2),
        .BCD3       (BCD3),
        .Seg        (Seg),
        .Dp         (Dp),
        .An         (An),
        .FrameStart (FrameStart)
    );

    int vectors     = 0;
    int miscompares = 0;

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        vectors++;
        if (obs !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Reference model: edges since reset decide which digit slot is lit.
    int          k;
    logic [3:0]  mdig [4];
    logic        mblank [4];
    logic [3:0]  exp_an;
    logic [6:0]  exp_seg;
    logic        exp_fs;

    function automatic logic [6:0] ref_seg(input logic [3:0] d);
        logic [6:0] tbl [16];
        tbl = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                7'b0000000, 7'b0010000, 7'b1111111, 7'b1111111,
                7'b1111111, 7'b1111111, 7'b1111111, 7'b0111111};
        return tbl[d];
    endfunction

    task automatic model_edge();
        int p;
        if (Reset) begin
            k       = 0;
            exp_an  = 4'b1111;
            exp_seg = 7'b1111111;
            exp_fs  = 1'b0;
            for (int i = 0; i < 4; i++) begin
                mdig[i]   = 4'hE;
                mblank[i] = 1'b0;
            end
        end else begin
            k++;
            exp_fs = 1'b0;
            if (k % SP == 0) begin
                p = ((k / SP) - 1) % 4;
                if (p == 0) begin
                    mdig[0] = BCD0; mdig[1] = BCD1; mdig[2] = BCD2; mdig[3] = BCD3;
                    exp_fs  = 1'b1;
                    for (int i = 0; i < 4; i++) begin
                        mblank[i] = 1'b0;
`ifdef LEADING_ZERO_BLANK_EN
                        if (i > 0) begin
                            mblank[i] = 1'b1;
                            for (int j = i; j < 4; j++)
                                if (mdig[j] != 4'd0) mblank[i] = 1'b0;
                        end
`endif
                    end
                end
                exp_an  = 4'b1111 & ~(4'b0001 << p);
                exp_seg = mblank[p] ? 7'b1111111 : ref_seg(mdig[p]);
            end
        end
    endtask

    task automatic step();
        @(posedge Clk);
        model_edge();
        #1;
        check("an", {12'd0, An}, {12'd0, exp_an});
        check("seg", {9'd0, Seg}, {9'd0, exp_seg});
        check("framestart", {15'd0, FrameStart}, {15'd0, exp_fs});
        check("dp", {15'd0, Dp}, 16'd1);
    endtask

    task automatic set_bcd(input logic [15:0] v);
        {BCD3, BCD2, BCD1, BCD0} = v;
    endtask

    function automatic logic [3:0] rnd_digit();
        if ($urandom_range(0, 3) == 0) return 4'($urandom_range(10, 15));
        return 4'($urandom_range(0, 9));
    endfunction

    initial begin
        Reset = 1'b1;
        set_bcd(16'h0000);
        step();
        step();
        Reset = 1'b0;

        set_bcd(16'h0001);
        repeat (40) step();
        set_bcd(16'h9999);
        repeat (40) step();
        set_bcd(16'hFFFF);
        repeat (40) step();
        set_bcd(16'h1234);
        repeat (22) step();
        set_bcd(16'h5678);
        repeat (40) step();

        Reset = 1'b1;
        step();
        Reset = 1'b0;
        repeat (30) step();

        for (int c = 0; c < 3000; c++) begin
            case ($urandom_range(0, 15))
                0: set_bcd({rnd_digit(), rnd_digit(), rnd_digit(), rnd_digit()});
                1: set_bcd({4'd0, 4'd0, rnd_digit(), rnd_digit()});
                2: set_bcd({4'd0, 4'd0, 4'd0, rnd_digit()});
                3: set_bcd({4'd0, rnd_digit(), 4'd0, rnd_digit()});
                default: ;
            endcase
            Reset = ($urandom_range(0, 199) == 0);
            step();
        end
        Reset = 1'b0;
        repeat (20) step();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
